// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU comparator: FSM states, the
// three-way chunk verdict and the registered flag bundle.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cmp_state_e;

   typedef enum logic [1:0] {
      CMP_LT = 2'd0,
      CMP_EQ = 2'd1,
      CMP_GT = 2'd2
   } cmp_res_e;

   typedef struct packed {
      logic eq;
      logic neq;
      logic lt;
      logic lte;
      logic gt;
      logic gte;
   } cmp_flags_t;

   // Expand a three-way verdict into the full flag set; exactly one of
   // lt/eq/gt ends up set and the rest are derived from those three.
   function automatic cmp_flags_t makeFlags(input cmp_res_e res);
      cmp_flags_t f;
      f.lt  = (res == CMP_LT);
      f.eq  = (res == CMP_EQ);
      f.gt  = (res == CMP_GT);
      f.neq = ~f.eq;
      f.lte = f.lt | f.eq;
      f.gte = f.gt | f.eq;
      return f;
   endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice pair. Flipping the
// top bit of both slices turns a two's-complement top chunk into
// offset-binary so the same unsigned compare orders signed values.
module cmp_chunk
   import alu_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] aChunk_i,
   input  logic [CHUNK-1:0] bChunk_i,
   input  logic             invertMsb_i,
   output cmp_res_e         res_o
);

   logic [CHUNK-1:0] aMod;
   logic [CHUNK-1:0] bMod;

   // Optionally flip the sign bit, then produce the three-way verdict
   always_comb begin
      aMod = aChunk_i;
      bMod = bChunk_i;
      aMod[CHUNK-1] = aChunk_i[CHUNK-1] ^ invertMsb_i;
      bMod[CHUNK-1] = bChunk_i[CHUNK-1] ^ invertMsb_i;
      if (aMod < bMod) begin
         res_o = CMP_LT;
      end else if (aMod > bMod) begin
         res_o = CMP_GT;
      end else begin
         res_o = CMP_EQ;
      end
   end

endmodule

// File: rtl/alu_seq_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle
// from the MSB down, remembers the first differing chunk, and presents the
// eq/neq/lt/lte/gt/gte flag set behind a valid/ready handshake.
module alu_seq_comparator
   import alu_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int CHUNK      = 4,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             neq,
   output logic             lt,
   output logic             lte,
   output logic             gt,
   output logic             gte
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   // Reject operand/chunk geometries that would leave a partial chunk
   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gBadGeometry
      $error("alu_seq_comparator: WIDTH must be a positive multiple of CHUNK");
   end

   cmp_state_e       stateQ, stateD;
   logic [WIDTH-1:0] aQ, aD;
   logic [WIDTH-1:0] bQ, bD;
   logic             signedQ, signedD;
   logic [IDXW-1:0]  idxQ, idxD;
   logic             decidedQ, decidedD;
   cmp_res_e         resQ, resD;
   cmp_flags_t       flagsQ, flagsD;

   logic [WIDTH-1:0] aShift;
   logic [WIDTH-1:0] bShift;
   logic [CHUNK-1:0] aSel;
   logic [CHUNK-1:0] bSel;
   logic             invertMsb;
   cmp_res_e         chunkRes;

   // Select the current chunk by shifting it up to the MSB position
   always_comb begin
      aShift    = aQ << (idxQ * CHUNK);
      bShift    = bQ << (idxQ * CHUNK);
      aSel      = aShift[WIDTH-1 -: CHUNK];
      bSel      = bShift[WIDTH-1 -: CHUNK];
      invertMsb = signedQ && (idxQ == '0);
   end

   cmp_chunk #(
      .CHUNK (CHUNK)
   ) uChunk (
      .aChunk_i    (aSel),
      .bChunk_i    (bSel),
      .invertMsb_i (invertMsb),
      .res_o       (chunkRes)
   );

   // Next-state logic: accept in IDLE, scan chunks in RUN, hold result in DONE
   always_comb begin
      stateD   = stateQ;
      aD       = aQ;
      bD       = bQ;
      signedD  = signedQ;
      idxD     = idxQ;
      decidedD = decidedQ;
      resD     = resQ;
      flagsD   = flagsQ;
      unique case (stateQ)
         IDLE: begin
            if (in_valid) begin
               aD       = a;
               bD       = b;
               signedD  = is_signed;
               idxD     = '0;
               decidedD = 1'b0;
               resD     = CMP_EQ;
               stateD   = RUN;
            end
         end
         RUN: begin
            if (!decidedQ) begin
               resD     = chunkRes;
               decidedD = (chunkRes != CMP_EQ);
            end
            if ((decidedD && EARLY_EXIT) || (idxQ == LAST_IDX)) begin
               flagsD = makeFlags(resD);
               stateD = DONE;
            end else begin
               idxD = idxQ + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               stateD = IDLE;
            end
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= IDLE;
         aQ       <= '0;
         bQ       <= '0;
         signedQ  <= 1'b0;
         idxQ     <= '0;
         decidedQ <= 1'b0;
         resQ     <= CMP_EQ;
         flagsQ   <= '0;
      end else begin
         stateQ   <= stateD;
         aQ       <= aD;
         bQ       <= bD;
         signedQ  <= signedD;
         idxQ     <= idxD;
         decidedQ <= decidedD;
         resQ     <= resD;
         flagsQ   <= flagsD;
      end
   end

   // Handshake and flag outputs straight from registered state
   always_comb begin
      in_ready  = (stateQ == IDLE) && !rst;
      out_valid = (stateQ == DONE);
      eq        = flagsQ.eq;
      neq       = flagsQ.neq;
      lt        = flagsQ.lt;
      lte       = flagsQ.lte;
      gt        = flagsQ.gt;
      gte       = flagsQ.gte;
   end

endmodule
